// File: rtl/compare_pkg.sv
// Shared definitions for the compare operand feeder: FSM encodings, default
// operand geometry and counter sizing.
package compare_pkg;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] CLEAR = 3'd1;
  localparam logic [2:0] FEED  = 3'd2;
  localparam logic [2:0] DRAIN = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  localparam int unsigned DEF_N  = 16384;
  localparam int unsigned DEF_W  = 2;
  localparam int unsigned DEF_LW = 32;

  // Bits needed to hold 0..max_val inclusive (never less than one bit).
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/compare_digit_shreg.sv
// LW-bit load/shift buffer that hands out W-bit digits MSB first and reports
// when it is empty or about to be (so a new word can be taken without a bubble).
module compare_digit_shreg
  import compare_pkg::*;
#(
  parameter int unsigned W  = DEF_W,
  parameter int unsigned LW = DEF_LW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [LW-1:0] word,
  output logic [W-1:0]  dig,
  output logic          empty,
  output logic          refill_next
);

  localparam int unsigned DW = LW / W;
  localparam int unsigned CW = cnt_width(DW);

  logic [LW-1:0] buf_q;
  logic [LW-1:0] buf_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign empty = (cnt_q == '0);

  // An empty buffer forwards the incoming word's top digit directly so the
  // first digit of a word costs no extra cycle; a load on the last digit
  // parks the whole word for the following cycles.
  always_comb begin
    buf_d = buf_q;
    cnt_d = cnt_q;
    dig   = '0;
    if (empty) begin
      if (load) begin
        dig   = word[LW-1 -: W];
        buf_d = word << W;
        cnt_d = CW'(DW - 1);
      end
    end else begin
      dig = buf_q[LW-1 -: W];
      if (load) begin
        buf_d = word;
        cnt_d = CW'(DW);
      end else begin
        buf_d = buf_q << W;
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  assign refill_next = (cnt_d <= CW'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_q <= '0;
      cnt_q <= '0;
    end else begin
      buf_q <= buf_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/compare_operand_feeder.sv
// Streams two N-bit operands, loaded as LW-bit word pairs, into an MSB-first
// digit comparator and captures the comparator's final verdict.
module compare_operand_feeder
  import compare_pkg::*;
#(
  parameter int unsigned N  = DEF_N,
  parameter int unsigned W  = DEF_W,
  parameter int unsigned LW = DEF_LW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  input  logic [LW-1:0] in_x_word,
  input  logic [LW-1:0] in_y_word,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [W-1:0]  x_dig,
  output logic [W-1:0]  y_dig,
  output logic          cmp_clr,
  input  logic          cmp_g,
  input  logic          cmp_e,
  output logic          res_valid,
  output logic          res_gt,
  output logic          res_eq
);

  localparam int unsigned NW  = N / LW;
  localparam int unsigned WCW = cnt_width(NW);

  logic [2:0]     state;
  logic [2:0]     state_d;
  logic [WCW-1:0] words;
  logic [WCW-1:0] words_d;
  logic           drain_second;
  logic           ready_d;
  logic           launch;
  logic           accept;
  logic [W-1:0]   x_next;
  logic [W-1:0]   y_next;
  logic           x_empty;
  logic           y_empty;
  logic           x_refill;
  logic           y_refill;

  assign launch = (state == IDLE) && start;
  assign accept = in_valid && in_ready;

  compare_digit_shreg #(.W(W), .LW(LW)) u_x_shreg (
    .clk         (clk),
    .rst         (rst),
    .load        (accept),
    .word        (in_x_word),
    .dig         (x_next),
    .empty       (x_empty),
    .refill_next (x_refill)
  );

  compare_digit_shreg #(.W(W), .LW(LW)) u_y_shreg (
    .clk         (clk),
    .rst         (rst),
    .load        (accept),
    .word        (in_y_word),
    .dig         (y_next),
    .empty       (y_empty),
    .refill_next (y_refill)
  );

  always_comb begin
    state_d = state;
    words_d = words;
    case (state)
      IDLE: if (start) begin
        state_d = CLEAR;
        words_d = '0;
      end
      CLEAR: state_d = FEED;
      FEED:  if ((words == WCW'(NW)) && x_empty && y_empty) state_d = DRAIN;
      DRAIN: if (drain_second) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (accept) words_d = words + 1'b1;
    // in_ready is registered, so it is derived from next-cycle buffer state.
    ready_d = ((state_d == CLEAR) || (state_d == FEED)) && x_refill && y_refill
              && (words_d < WCW'(NW));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      words        <= '0;
      drain_second <= 1'b0;
      busy         <= 1'b0;
      in_ready     <= 1'b0;
      x_dig        <= '0;
      y_dig        <= '0;
      cmp_clr      <= 1'b0;
      res_valid    <= 1'b0;
      res_gt       <= 1'b0;
      res_eq       <= 1'b0;
    end else begin
      state        <= state_d;
      words        <= words_d;
      in_ready     <= ready_d;
      x_dig        <= x_next;
      y_dig        <= y_next;
      cmp_clr      <= launch;
      res_valid    <= (state == DRAIN) && drain_second;
      drain_second <= (state == DRAIN) && !drain_second;
      if (launch) begin
        busy <= 1'b1;
      end else if (state == DONE) begin
        busy <= 1'b0;
      end
      // Comparator flags settle one cycle after the last digit is absorbed.
      if (state == CLEAR) begin
        res_gt <= 1'b0;
        res_eq <= 1'b0;
      end else if ((state == DRAIN) && !drain_second) begin
        res_gt <= cmp_g;
        res_eq <= cmp_e;
      end
    end
  end

endmodule

// File: tb/tb_compare_operand_feeder.sv
// Directed bench for compare_operand_feeder: a small (N=8, LW=4) and a default
// sized instance, each driving a behavioural MSB-first digit comparator.
module tb_compare_operand_feeder;

  localparam int unsigned SN  = 8;
  localparam int unsigned SLW = 4;
  localparam int unsigned BN  = 16384;
  localparam int unsigned BLW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic           s_start, s_in_valid, s_busy, s_ready, s_clr, s_cg, s_ce, s_rv, s_gt, s_eq;
  logic [SLW-1:0] s_xw, s_yw;
  logic [1:0]     s_xd, s_yd;
  logic           b_start, b_in_valid, b_busy, b_ready, b_clr, b_cg, b_ce, b_rv, b_gt, b_eq;
  logic [BLW-1:0] b_xw, b_yw;
  logic [1:0]     b_xd, b_yd;

  compare_operand_feeder #(.N(SN), .W(2), .LW(SLW)) dut_s (
    .clk(clk), .rst(rst), .start(s_start), .busy(s_busy),
    .in_x_word(s_xw), .in_y_word(s_yw), .in_valid(s_in_valid), .in_ready(s_ready),
    .x_dig(s_xd), .y_dig(s_yd), .cmp_clr(s_clr), .cmp_g(s_cg), .cmp_e(s_ce),
    .res_valid(s_rv), .res_gt(s_gt), .res_eq(s_eq)
  );

  compare_operand_feeder dut_b (
    .clk(clk), .rst(rst), .start(b_start), .busy(b_busy),
    .in_x_word(b_xw), .in_y_word(b_yw), .in_valid(b_in_valid), .in_ready(b_ready),
    .x_dig(b_xd), .y_dig(b_yd), .cmp_clr(b_clr), .cmp_g(b_cg), .cmp_e(b_ce),
    .res_valid(b_rv), .res_gt(b_gt), .res_eq(b_eq)
  );

  // Behavioural comparators: first unequal digit decides, equal digits keep state.
  always @(posedge clk or posedge rst) begin
    if (rst || s_clr) begin
      s_cg <= 1'b0;
      s_ce <= 1'b1;
    end else if (s_ce && (s_xd != s_yd)) begin
      s_cg <= (s_xd > s_yd);
      s_ce <= 1'b0;
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst || b_clr) begin
      b_cg <= 1'b0;
      b_ce <= 1'b1;
    end else if (b_ce && (b_xd != b_yd)) begin
      b_cg <= (b_xd > b_yd);
      b_ce <= 1'b0;
    end
  end

  int n_cmp  = 0;
  int n_fail = 0;
  logic [1:0] sb[$];
  logic [3:0] dq[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sample(input bit big, output logic busy, output logic ready, output logic rv,
                        output logic gt, output logic eq, output logic clr,
                        output logic [1:0] xd, output logic [1:0] yd);
    if (big) begin
      busy = b_busy; ready = b_ready; rv = b_rv; gt = b_gt; eq = b_eq; clr = b_clr; xd = b_xd; yd = b_yd;
    end else begin
      busy = s_busy; ready = s_ready; rv = s_rv; gt = s_gt; eq = s_eq; clr = s_clr; xd = s_xd; yd = s_yd;
    end
  endtask

  task automatic drive(input bit big, input logic st, input logic v,
                       input logic [31:0] wx, input logic [31:0] wy);
    if (big) begin
      b_start = st; b_in_valid = v; b_xw = wx; b_yw = wy;
    end else begin
      s_start = st; s_in_valid = v; s_xw = wx[SLW-1:0]; s_yw = wy[SLW-1:0];
    end
  endtask

  // One operation, cycle by cycle: c=0 is the cycle in which start is sampled.
  task automatic run_op(input bit big, input logic [BN-1:0] x, input logic [BN-1:0] y,
                        input int gap_after, input int gap_len, input int bub_every,
                        input int exp_lat, input int exp_zero, input bit chk_dig,
                        input bit hold_start, input bit extra, input int rst_at);
    int n = big ? BN : SN;
    int lw = big ? BLW : SLW;
    int nw = n / lw;
    int nd = n / 2;
    int limit = nd + nd / 8 + 40;
    int widx = 0, gap_left = 0, done_c = -1, nrv = 0, nzero = 0, idx;
    bit pv = 1'b0, pr = 1'b0, v;
    logic o_busy, o_ready, o_rv, o_gt, o_eq, o_clr;
    logic [1:0] o_xd, o_yd, e_res;
    logic [3:0] e_dig;
    logic [BN-1:0] sx, sy;
    string tg = big ? "big" : "small";

    sb.push_back({x > y, x == y});
    if (chk_dig) begin
      for (int k = 0; k < nd; k++) begin
        sx = x >> (n - 2 * (k + 1));
        sy = y >> (n - 2 * (k + 1));
        dq.push_back({sx[1:0], sy[1:0]});
      end
    end

    for (int c = 0; c < limit; c++) begin
      @(negedge clk);
      if (pv && pr) begin
        widx++;
        if ((gap_after >= 0) && (widx == gap_after + 1)) gap_left = gap_len;
      end
      sample(big, o_busy, o_ready, o_rv, o_gt, o_eq, o_clr, o_xd, o_yd);

      if (c == rst_at) begin
        rst = 1'b1;
        #1;
        sample(big, o_busy, o_ready, o_rv, o_gt, o_eq, o_clr, o_xd, o_yd);
        chk({tg, "_rst_busy"}, o_busy, 0);
        chk({tg, "_rst_xdig"}, o_xd, 0);
        chk({tg, "_rst_ydig"}, o_yd, 0);
        chk({tg, "_rst_gt"}, o_gt, 0);
        chk({tg, "_rst_eq"}, o_eq, 0);
        chk({tg, "_rst_ready"}, o_ready, 0);
        drive(big, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        dq.delete();
        return;
      end

      if (done_c >= 0) begin
        chk({tg, "_post_busy"}, o_busy, 0);
        chk({tg, "_post_rv"}, o_rv, 0);
        if (c >= done_c + 3) break;
      end else begin
        if (o_rv) begin
          nrv++;
          done_c = c;
          chk({tg, "_busy_at_rv"}, o_busy, 1);
          if (exp_lat > 0) chk({tg, "_latency"}, c, exp_lat);
          if (sb.size() > 0) begin
            e_res = sb.pop_front();
            chk({tg, "_res_gt"}, o_gt, e_res[1]);
            chk({tg, "_res_eq"}, o_eq, e_res[0]);
          end else begin
            chk({tg, "_unexpected_rv"}, o_rv, 0);
          end
        end
        if (chk_dig && (c >= 2) && (c < 2 + nd) && (dq.size() > 0)) begin
          e_dig = dq.pop_front();
          chk({tg, "_digits"}, {o_xd, o_yd}, e_dig);
        end
        if ((exp_zero >= 0) && (c >= 2) && (c <= exp_lat - 3) && (o_xd == 2'b00) && (o_yd == 2'b00))
          nzero++;
        if (extra && (widx >= nw) && (c > 0))
          chk({tg, "_ready_after_nw"}, o_ready, 0);
        if (c == 1) chk({tg, "_cmp_clr"}, o_clr, 1);
      end

      v = 1'b0;
      if (done_c < 0) begin
        if (widx < nw) begin
          v = (gap_left == 0) && !((bub_every > 0) && (c % bub_every == 0));
          if (gap_left > 0) gap_left--;
        end else begin
          v = extra;
        end
      end
      idx = (widx < nw) ? widx : 0;
      sx = x >> (n - lw * (idx + 1));
      sy = y >> (n - lw * (idx + 1));
      drive(big, (c == 0) || (hold_start && (done_c < 0)), v, sx[31:0], sy[31:0]);
      pv = v;
      pr = o_ready;
    end

    drive(big, 1'b0, 1'b0, '0, '0);
    chk({tg, "_res_valid_count"}, nrv, 1);
    if (exp_zero >= 0) chk({tg, "_zero_pairs"}, nzero, exp_zero);
    sb.delete();
    dq.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [BN-1:0] bx, by;
    logic o_busy, o_ready, o_rv, o_gt, o_eq, o_clr;
    logic [1:0] o_xd, o_yd;

    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    repeat (3) @(negedge clk);
    for (int b = 0; b < 2; b++) begin
      sample(b[0], o_busy, o_ready, o_rv, o_gt, o_eq, o_clr, o_xd, o_yd);
      chk("reset_busy", o_busy, 0);
      chk("reset_ready", o_ready, 0);
      chk("reset_rv", o_rv, 0);
      chk("reset_gt", o_gt, 0);
      chk("reset_eq", o_eq, 0);
      chk("reset_clr", o_clr, 0);
      chk("reset_digits", {o_xd, o_yd}, 0);
    end
    rst = 1'b0;
    @(negedge clk);

    // A5 vs 5A back to back: digits 10,10,01,01 vs 01,01,10,10, x greater.
    run_op(1'b0, BN'(8'hA5), BN'(8'h5A), -1, 0, 0, 8, -1, 1'b1, 1'b0, 1'b0, -1);
    // Equal operands, result at N/W+4.
    run_op(1'b0, BN'(8'h3C), BN'(8'h3C), -1, 0, 0, 8, -1, 1'b1, 1'b0, 1'b0, -1);
    // 3-cycle hole after word 0: two bubbles plus the genuine 00/00 digit pair.
    run_op(1'b0, BN'(8'h70), BN'(8'h71), 0, 3, 0, 10, 3, 1'b0, 1'b0, 1'b0, -1);
    // start held and a third word offered: ignored, single result.
    run_op(1'b0, BN'(8'h12), BN'(8'h34), -1, 0, 0, 8, -1, 1'b0, 1'b1, 1'b1, -1);
    // Reset in the middle of the second digit of word 0, then a clean operation.
    run_op(1'b0, BN'(8'hA5), BN'(8'h5A), -1, 0, 0, 8, -1, 1'b0, 1'b0, 1'b0, 3);
    run_op(1'b0, BN'(8'hC3), BN'(8'hC1), -1, 0, 0, 8, -1, 1'b1, 1'b0, 1'b0, -1);

    // Full-size operands with a bubble every 17 cycles.
    for (int i = 0; i < BN / 32; i++) begin
      bx[i*32 +: 32] = $urandom();
      by[i*32 +: 32] = $urandom();
    end
    run_op(1'b1, bx, by, -1, 0, 17, 0, -1, 1'b0, 1'b0, 1'b0, -1);
    by = bx;
    bx[0] = 1'b1;
    by[0] = 1'b0;
    run_op(1'b1, bx, by, -1, 0, 17, 0, -1, 1'b0, 1'b0, 1'b0, -1);
    run_op(1'b1, by, by, -1, 0, 17, 0, -1, 1'b0, 1'b0, 1'b0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
